// File: rtl/branch_predictor_gshare.sv
// Gshare/bimodal branch predictor: 2-bit saturating PHT, speculative global history,
// and an in-flight queue that repairs history and trains the PHT as branches resolve.
module branch_predictor_gshare #(
    parameter int TABLE_BITS = 6,
    parameter int HIST_BITS  = 4,
    parameter int MODE       = 1,
    parameter int BACK_TAKEN = 1,
    parameter int INFL_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        decode_valid,
    input  logic [31:0] decode_pc,
    input  logic [31:0] decode_offset,
    output logic [31:0] target_addr,
    output logic        prediction,
    input  logic        resolve_valid,
    input  logic        resolve_taken,
    input  logic        flush,
    output logic        inflight_full,
    output logic        mispredict,
    output logic        resolve_err
);
    localparam int ENTRIES = 1 << TABLE_BITS;
    localparam int PTR_W   = (INFL_DEPTH > 1) ? $clog2(INFL_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;

    logic [1:0]            pht_q [ENTRIES];
    logic [HIST_BITS-1:0]  ghr_q, ghr_d;
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  mispredict_q, mispredict_d;
    logic                  resolve_err_q, resolve_err_d;

    logic [TABLE_BITS-1:0] q_idx_q  [INFL_DEPTH];
    logic                  q_pred_q [INFL_DEPTH];
    logic [HIST_BITS-1:0]  q_ghr_q  [INFL_DEPTH];

    logic [TABLE_BITS-1:0] idx;
    logic                  empty;
    logic                  push_req, push, pop, mis_now;
    logic [HIST_BITS-1:0]  ghr_shifted, ghr_restored;
    logic [TABLE_BITS-1:0] head_idx;
    logic                  head_pred;
    logic [HIST_BITS-1:0]  head_ghr;
    logic [1:0]            head_cnt, pht_wdata;

    assign head_idx  = q_idx_q[head_q];
    assign head_pred = q_pred_q[head_q];
    assign head_ghr  = q_ghr_q[head_q];
    assign head_cnt  = pht_q[head_idx];

    // Single-bit history degenerates to "last outcome only", so the slice is avoided there.
    generate
        if (HIST_BITS == 1) begin : g_hist1
            assign ghr_shifted  = prediction;
            assign ghr_restored = resolve_taken;
        end else begin : g_histn
            assign ghr_shifted  = {ghr_q[HIST_BITS-2:0], prediction};
            assign ghr_restored = {head_ghr[HIST_BITS-2:0], resolve_taken};
        end
    endgenerate

    always_comb begin
        idx = decode_pc[TABLE_BITS+1:2];
        if (MODE == 1) begin
            idx = idx ^ TABLE_BITS'(ghr_q);
        end
    end

    assign target_addr   = decode_pc + decode_offset;
    assign inflight_full = (count_q == CNT_W'(INFL_DEPTH));
    assign empty         = (count_q == '0);
    assign prediction    = decode_valid & ~inflight_full &
                           (pht_q[idx][1] | ((BACK_TAKEN != 0) & decode_offset[31]));

    always_comb begin
        push_req      = decode_valid & ~inflight_full;
        pop           = resolve_valid & ~empty & ~flush;
        mis_now       = pop & (resolve_taken != head_pred);
        push          = push_req & ~flush & ~mis_now;
        resolve_err_d = resolve_valid & empty;
        mispredict_d  = mis_now;
        ghr_d         = ghr_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        pht_wdata     = head_cnt;

        if (resolve_taken) begin
            pht_wdata = (head_cnt == 2'b11) ? 2'b11 : head_cnt + 2'b01;
        end else begin
            pht_wdata = (head_cnt == 2'b00) ? 2'b00 : head_cnt - 2'b01;
        end

        if (flush || mis_now) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (mis_now) begin
                ghr_d = ghr_restored;
            end
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
                ghr_d  = ghr_shifted;
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Each counter is its own flop pair so reset can clear the whole table at once.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_pht
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pht_q[gi] <= 2'b01;
                end else if (pop && (head_idx == TABLE_BITS'(gi))) begin
                    pht_q[gi] <= pht_wdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghr_q         <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            mispredict_q  <= 1'b0;
            resolve_err_q <= 1'b0;
        end else begin
            ghr_q         <= ghr_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            mispredict_q  <= mispredict_d;
            resolve_err_q <= resolve_err_d;
        end
    end

    // Payload needs no reset: entries are only read while the occupancy says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_idx_q[tail_q]  <= idx;
            q_pred_q[tail_q] <= prediction;
            q_ghr_q[tail_q]  <= ghr_q;
        end
    end

    assign mispredict  = mispredict_q;
    assign resolve_err = resolve_err_q;
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for branch_predictor_gshare with default parameters (gshare, 64-entry PHT,
// 4-bit history, depth-4 queue); expected values are worked out by hand per step.
module tb_branch_predictor_gshare;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        decode_valid;
    logic [31:0] decode_pc;
    logic [31:0] decode_offset;
    logic [31:0] target_addr;
    logic        prediction;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        flush;
    logic        inflight_full;
    logic        mispredict;
    logic        resolve_err;

    int n_cmp = 0;
    int n_bad = 0;

    branch_predictor_gshare dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .decode_valid (decode_valid),
        .decode_pc    (decode_pc),
        .decode_offset(decode_offset),
        .target_addr  (target_addr),
        .prediction   (prediction),
        .resolve_valid(resolve_valid),
        .resolve_taken(resolve_taken),
        .flush        (flush),
        .inflight_full(inflight_full),
        .mispredict   (mispredict),
        .resolve_err  (resolve_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic idle();
        decode_valid  = 1'b0;
        decode_pc     = '0;
        decode_offset = '0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        flush         = 1'b0;
    endtask

    // Advance one clock, then settle just past the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic [31:0] pc, input logic [31:0] off);
        decode_valid  = 1'b1;
        decode_pc     = pc;
        decode_offset = off;
    endtask

    task automatic res(input logic taken);
        resolve_valid = 1'b1;
        resolve_taken = taken;
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        check_eq("rst_mispredict", mispredict, 0);
        check_eq("rst_resolve_err", resolve_err, 0);
        check_eq("rst_full", inflight_full, 0);
        check_eq("rst_ghr", dut.ghr_q, 0);

        // Scenario 1: forward branch, fresh PHT -> not taken; resolves taken.
        dec(32'h40, 32'd8); #1;
        check_eq("s1_pred", prediction, 0);
        check_eq("s1_target", target_addr, 32'h48);
        step(); idle(); res(1'b1);
        step(); idle();
        check_eq("s1_mispredict", mispredict, 1);
        check_eq("s1_pht10", dut.pht_q[16], 2);
        check_eq("s1_ghr", dut.ghr_q, 1);
        check_eq("s1_count", dut.count_q, 0);
        #1;
        // pc 0x44 -> 0x11 ^ ghr 1 = 0x10, which is now weakly taken
        dec(32'h44, 32'd4); #1;
        check_eq("s1_reuse_pred", prediction, 1);
        step(); idle();
        check_eq("s1_mispredict_gone", mispredict, 0);
        res(1'b1);
        step(); idle();
        check_eq("s1_correct_no_mis", mispredict, 0);
        check_eq("s1_ghr2", dut.ghr_q, 3);

        // Scenario 2: backward branch predicted taken by direction, resolves not-taken.
        dec(32'h100, 32'hFFFF_FFF0); #1;
        check_eq("s2_pred", prediction, 1);
        check_eq("s2_target", target_addr, 32'hF0);
        step(); idle(); res(1'b0);
        step(); idle();
        check_eq("s2_mispredict", mispredict, 1);
        check_eq("s2_pht3", dut.pht_q[3], 0);
        check_eq("s2_ghr", dut.ghr_q, 6);
        dec(32'h114, 32'hFFFF_FFF0); #1;
        check_eq("s2b_pred", prediction, 1);
        step(); idle(); res(1'b0);
        step(); idle();
        check_eq("s2b_pht3_sat", dut.pht_q[3], 0);
        check_eq("s2b_ghr", dut.ghr_q, 12);

        // Scenario 3: fill the queue with four not-taken forward branches.
        for (int i = 0; i < 4; i++) begin
            dec(32'h200, 32'd4); #1;
            check_eq($sformatf("s3_pred%0d", i), prediction, 0);
            step(); idle();
        end
        check_eq("s3_full", inflight_full, 1);
        check_eq("s3_count", dut.count_q, 4);
        dec(32'h200, 32'hFFFF_FFF0); #1;
        check_eq("s3_fifth_pred", prediction, 0);
        res(1'b0); #1;
        check_eq("s3_full_during_pop", inflight_full, 1);
        step(); idle();
        check_eq("s3_no_mis", mispredict, 0);
        check_eq("s3_count_after", dut.count_q, 3);
        check_eq("s3_ghr", dut.ghr_q, 0);
        for (int i = 0; i < 3; i++) begin
            res(1'b0);
            step(); idle();
        end
        check_eq("s3_drained", dut.count_q, 0);
        check_eq("s3_not_full", inflight_full, 0);

        // Scenario 4: seed history, three taken-predicted pushes, first resolve mispredicts.
        dec(32'h200, 32'hFFFF_FFF0);
        step(); idle(); res(1'b1);
        step(); idle();
        check_eq("s4_seed_ghr", dut.ghr_q, 1);
        for (int i = 0; i < 3; i++) begin
            dec(32'h200, 32'hFFFF_FFF0); #1;
            check_eq($sformatf("s4_pred%0d", i), prediction, 1);
            step(); idle();
        end
        check_eq("s4_ghr_spec", dut.ghr_q, 15);
        res(1'b0);
        dec(32'h300, 32'hFFFF_FFF0);
        step(); idle();
        check_eq("s4_mispredict", mispredict, 1);
        check_eq("s4_empty", dut.count_q, 0);
        check_eq("s4_ghr_restored", dut.ghr_q, 2);
        check_eq("s4_pht1", dut.pht_q[1], 0);

        // Scenario 5: resolve with nothing in flight.
        res(1'b1);
        step(); idle();
        check_eq("s5_resolve_err", resolve_err, 1);
        check_eq("s5_no_mis", mispredict, 0);
        check_eq("s5_ghr", dut.ghr_q, 2);
        check_eq("s5_pht0", dut.pht_q[0], 1);
        step();
        check_eq("s5_err_clears", resolve_err, 0);

        // Flush drops the queue plus a same-cycle push and pop; history keeps its value.
        dec(32'h200, 32'd4);
        step(); idle();
        check_eq("fl_ghr_pre", dut.ghr_q, 4);
        flush = 1'b1; res(1'b1); dec(32'h200, 32'd4);
        step(); idle();
        check_eq("fl_count", dut.count_q, 0);
        check_eq("fl_ghr", dut.ghr_q, 4);
        check_eq("fl_no_mis", mispredict, 0);
        check_eq("fl_pht2", dut.pht_q[2], 1);

        // Scenario 6: asynchronous reset between edges with two entries queued.
        dec(32'h200, 32'd4); step();
        dec(32'h200, 32'd4); step(); idle();
        check_eq("s6_count_pre", dut.count_q, 2);
        #2 reset_n = 1'b0;
        #1;
        check_eq("s6_count", dut.count_q, 0);
        check_eq("s6_ghr", dut.ghr_q, 0);
        check_eq("s6_full", inflight_full, 0);
        check_eq("s6_mis", mispredict, 0);
        check_eq("s6_err", resolve_err, 0);
        check_eq("s6_pht3", dut.pht_q[3], 1);
        #2 reset_n = 1'b1;
        step();
        dec(32'h40, 32'd8); #1;
        check_eq("s6_post_pred", prediction, 0);
        step(); idle(); res(1'b1);
        step(); idle();
        check_eq("s6_post_mis", mispredict, 1);
        check_eq("s6_post_ghr", dut.ghr_q, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/branch_predictor_gshare.md
BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 The block SHALL have the parameter TABLE_BITS, default 6, meaning log2 of the pattern-history-table (PHT) entry count.
REQ-002 The block SHALL have the parameter HIST_BITS, default 4, meaning global-history-register (GHR) width; it SHALL be legal from 1 to TABLE_BITS.
REQ-003 The block SHALL have the parameter MODE, default 1, meaning the index mode: 0 is bimodal (PC only), 1 is gshare (PC XOR GHR).
REQ-004 The block SHALL have the parameter BACK_TAKEN, default 1, meaning a backward branch (offset[31]=1) is always predicted taken when it is 1.
REQ-005 The block SHALL have the parameter INFL_DEPTH, default 4, meaning the in-flight queue depth; it SHALL be a power of 2 and at least 2.
REQ-006 The port clk SHALL be an input, 1 bit: the only clock; all state SHALL change on its rising edge.
REQ-007 The port reset_n SHALL be an input, 1 bit: the reset, asynchronous and active-low.
REQ-008 The port decode_valid SHALL be an input, 1 bit: a branch is in ID this cycle.
REQ-009 The port decode_pc SHALL be an input, 32 bits: the PC of the decoded branch.
REQ-010 The port decode_offset SHALL be an input, 32 bits: the sign-extended branch immediate.
REQ-011 The port target_addr SHALL be an output, 32 bits: decode_pc + decode_offset, modulo 2^32.
REQ-012 The port prediction SHALL be an output, 1 bit: 1 means predicted taken; it is combinational.
REQ-013 The port resolve_valid SHALL be an input, 1 bit: the oldest in-flight branch resolves in MEM this cycle.
REQ-014 The port resolve_taken SHALL be an input, 1 bit: the actual outcome of the resolving branch.
REQ-015 The port flush SHALL be an input, 1 bit: the pipeline squashes all in-flight branches.
REQ-016 The port inflight_full SHALL be an output, 1 bit: the queue holds INFL_DEPTH entries, and the pipeline must stall decode.
REQ-017 The port mispredict SHALL be an output, 1 bit: registered; it pulses when the previous cycle's resolve disagreed with its prediction.
REQ-018 The port resolve_err SHALL be an output, 1 bit: registered; it pulses when the previous cycle had resolve_valid while the queue was empty.

Function
REQ-019 The index SHALL be idx = decode_pc[TABLE_BITS+1:2] when MODE=0, and that value XOR the zero-extended GHR when MODE=1.
REQ-020 The prediction SHALL be decode_valid & ~inflight_full & (PHT[idx][1] | (BACK_TAKEN & decode_offset[31])).
REQ-021 A push SHALL occur when decode_valid & ~inflight_full; it writes {idx, prediction, GHR before the shift} to the queue tail.
REQ-022 On a push, the GHR SHALL shift speculatively: GHR <= {GHR[HIST_BITS-2:0], prediction}.
REQ-023 A pop SHALL occur when resolve_valid & queue non-empty; the head entry is consumed.
REQ-024 A pop SHALL update PHT[head.idx] saturating: a taken outcome adds 1 up to 11, and a not-taken outcome subtracts 1 down to 00.
REQ-025 The update in REQ-024 SHALL apply to backward branches too.
REQ-026 A misprediction SHALL be a pop where resolve_taken != head.prediction.
REQ-027 On a misprediction, the GHR SHALL be restored to {head.ghr[HIST_BITS-2:0], resolve_taken}.
REQ-028 On a misprediction, all remaining queue entries SHALL be discarded.
REQ-029 On a misprediction, any same-cycle push SHALL be dropped, together with its GHR shift.
REQ-030 mispredict SHALL be 1 for exactly the one cycle after a mispredicting pop, and 0 otherwise.
REQ-031 A same-cycle push and correct pop SHALL both take effect; the occupancy SHALL be unchanged, including when full (no push, because full gates push).
REQ-032 The PHT read and write SHALL be ordered so that a same-cycle lookup of the entry being updated returns the pre-update value (write on the clock edge).
REQ-033 flush SHALL empty the queue and drop any same-cycle push and pop, including the PHT update; the GHR SHALL be unchanged.
REQ-034 Queue pointers SHALL wrap modulo INFL_DEPTH.
REQ-035 Occupancy SHALL be tracked so that full and empty are distinguishable.
REQ-036 A resolve_valid on an empty queue SHALL leave all state unchanged and set resolve_err for one cycle.

Reset
REQ-037 reset_n=0 SHALL immediately set all PHT entries to 01, GHR=0, queue empty, mispredict=0, resolve_err=0 and inflight_full=0, independent of clk.
REQ-038 A reset asserted mid-operation SHALL discard all in-flight entries; the first push after release SHALL behave as one from power-up.

Verification
REQ-039 Scenario 1: after reset, MODE=1, decode pc=0x40 offset=+8 -> prediction=0 and target=0x48; then resolve taken -> mispredict=1 next cycle, PHT[0x10]=10 and GHR=0001.
REQ-040 Scenario 2: a decode with offset=0xFFFFFFF0 and a fresh PHT -> prediction=1; resolve not-taken -> mispredict=1 and the counter saturates at 00.
REQ-041 Scenario 3: four decodes with no resolve and INFL_DEPTH=4 -> inflight_full=1 and a fifth decode_valid gives prediction=0 with no push; a simultaneous correct resolve keeps full=1.
REQ-042 Scenario 4: three pushes, then the first resolve mispredicts -> the queue is empty next cycle and the GHR equals the restored value per REQ-027.
REQ-043 Scenario 5: resolve_valid with an empty queue -> resolve_err=1 for one cycle, and PHT and GHR are unchanged.
REQ-044 Scenario 6: reset_n pulsed low between clock edges with two entries queued -> all outputs reset with no clock edge, and the queue is empty.
